// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode constants, fetch-state encoding and the
// legal-opcode test used by both the fetch unit and the control unit.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // addi x0, x0, 0 -- presented to decode until the first real fetch lands
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } fetch_state_e;

   function automatic logic is_legal_opcode(input logic [6:0] op);
      logic legal;
      case (op)
         OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
         default:                                      legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential pc+4 (wrapping) or a taken branch target,
// plus a flag for word-misaligned targets.
module pc_next
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_branch_taken,
   input  logic [XLEN-1:0] i_branch_target,
   output logic [XLEN-1:0] o_next_pc,
   output logic            o_misaligned
);

   logic [XLEN-1:0] w_pc_plus4;

   // Truncation to XLEN gives the modulo-2^XLEN wrap at the top of memory.
   assign w_pc_plus4   = i_pc + XLEN'(4);
   assign o_next_pc    = i_branch_taken ? i_branch_target : w_pc_plus4;
   assign o_misaligned = i_branch_taken && (i_branch_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests the word at pc, validates its opcode, holds it
// for execute until retire, then advances or redirects; halts on any fault.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   output logic [6:0]      opcode,
   output logic [XLEN-1:0] pc,
   output logic            instr_valid,
   input  logic            retire,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            halted
);

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;
   logic            r_halted;
   logic            r_imem_req;
   logic            r_instr_valid;

   logic [XLEN-1:0] w_next_pc;
   logic            w_misaligned;

   pc_next #(
      .XLEN (XLEN)
   ) u_pc_next (
      .i_pc            (r_pc),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .o_next_pc       (w_next_pc),
      .o_misaligned    (w_misaligned)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would make results depend on statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_instr       <= NOP_INSTR;
         r_halted      <= 1'b0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state    <= REQ;
               r_imem_req <= 1'b1;
            end
            REQ: begin
               if (imem_ack) begin
                  r_instr    <= imem_rdata;
                  r_imem_req <= 1'b0;
                  if (is_legal_opcode(imem_rdata[6:0])) begin
                     r_state       <= ISSUE;
                     r_instr_valid <= 1'b1;
                  end else begin
                     r_state  <= HALT;
                     r_halted <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (retire) begin
                  r_instr_valid <= 1'b0;
                  // A misaligned redirect faults without touching pc.
                  if (w_misaligned) begin
                     r_state  <= HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc       <= w_next_pc;
                     r_state    <= REQ;
                     r_imem_req <= 1'b1;
                  end
               end
            end
            HALT: begin
               r_state <= HALT;
            end
            default: begin
               r_state <= HALT;
            end
         endcase
      end
   end

   // Handshake outputs are masked by rst so nothing is requested or issued
   // during the reset cycle itself, before the registers clear.
   assign imem_req    = r_imem_req & ~rst;
   assign instr_valid = r_instr_valid & ~rst;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign instr       = r_instr;
   assign opcode      = r_instr[6:0];
   assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// memory/execute behaviour compared against a transaction-level model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [31:0] pc;
   logic        instr_valid;
   logic        retire;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halted;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .opcode        (opcode),
      .pc            (pc),
      .instr_valid   (instr_valid),
      .retire        (retire),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halted        (halted)
   );

   int checks   = 0;
   int failures = 0;

   // Model: what the fetch unit holds, not how it sequences.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   bit          m_halted;
   bit          m_have;
   int          m_idle;
   bit          m_known = 1'b0;

   logic        s_req;
   logic        s_valid;
   logic        s_halted;
   logic [31:0] s_addr;
   logic [31:0] s_pc;

   logic [6:0] legal_ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                 7'b0100011, 7'b1100011};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
   endfunction

   // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
   task automatic cycle(input bit r, input bit a, input logic [31:0] d,
                        input bit ret, input bit tk, input logic [31:0] tgt);
      bit exp_req;
      bit exp_valid;
      rst           = r;
      imem_ack      = a;
      imem_rdata    = d;
      retire        = ret;
      branch_taken  = tk;
      branch_target = tgt;
      #1;
      s_req    = imem_req;
      s_valid  = instr_valid;
      s_halted = halted;
      s_addr   = imem_addr;
      s_pc     = pc;
      if (m_known) begin
         exp_req   = !r && !m_halted && (m_idle == 0) && !m_have;
         exp_valid = !r && !m_halted && (m_idle == 0) && m_have;
         check("imem_req",    32'(imem_req),    32'(exp_req));
         check("instr_valid", 32'(instr_valid), 32'(exp_valid));
         check("halted",      32'(halted),      32'(m_halted));
         check("pc",          pc,               m_pc);
         check("imem_addr",   imem_addr,        m_pc);
         check("instr",       instr,            m_instr);
         check("opcode",      32'(opcode),      32'(m_instr[6:0]));
      end
      if (r) begin
         m_pc     = RESET_PC;
         m_instr  = NOP;
         m_halted = 1'b0;
         m_have   = 1'b0;
         m_idle   = 1;
         m_known  = 1'b1;
      end else if (m_known && !m_halted) begin
         if (m_idle > 0) begin
            m_idle--;
         end else if (!m_have) begin
            if (a) begin
               m_instr = d;
               if (is_legal(d[6:0])) m_have = 1'b1;
               else                  m_halted = 1'b1;
            end
         end else if (ret) begin
            if (!tk) begin
               m_pc   = m_pc + 32'd4;
               m_have = 1'b0;
            end else if (tgt[1:0] == 2'b00) begin
               m_pc   = tgt;
               m_have = 1'b0;
            end else begin
               m_halted = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic fetch(input logic [31:0] word);
      cycle(1'b0, 1'b1, word, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic retire_cycle(input bit tk, input logic [31:0] tgt);
      cycle(1'b0, 1'b0, 32'h0, 1'b1, tk, tgt);
   endtask

   initial begin
      int          cnt_req;
      int          cnt_valid;
      logic [31:0] addrs[$];
      logic [31:0] w;
      logic [31:0] tgt;
      logic [31:0] rnd;
      bit          r;

      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
      retire = 1'b0; branch_taken = 1'b0; branch_target = '0;
      @(negedge clk);

      // Reset state, then back-to-back fetch with immediate ack and retire.
      do_reset();
      do_reset();
      idle_cycle();
      check("rst_pc", s_pc, RESET_PC);
      cnt_valid = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 32'h0000_0033, 1'b1, 1'b0, 32'h0);
         if (s_req) addrs.push_back(s_addr);
         if (s_valid) cnt_valid++;
      end
      check("tput_valid_count", 32'(cnt_valid), 32'd3);
      check("tput_req_count", 32'(addrs.size()), 32'd3);
      if (addrs.size() == 3) begin
         check("tput_addr0", addrs[0], 32'h0);
         check("tput_addr1", addrs[1], 32'h4);
         check("tput_addr2", addrs[2], 32'h8);
      end

      // Ack delayed by three cycles; ack also offered during IDLE is ignored.
      do_reset();
      fetch(32'h0000_0033);
      cnt_req = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, (i == 3), 32'h0000_0013, 1'b0, 1'b0, 32'h0);
         if (s_req) cnt_req++;
         check("delay_addr_stable", s_addr, RESET_PC);
      end
      check("delay_req_cycles", 32'(cnt_req), 32'd4);
      idle_cycle();
      check("delay_valid_after_ack", 32'(s_valid), 32'd1);
      // Branch inputs without retire are ignored.
      cycle(1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b1, 32'h0000_0200);
      retire_cycle(1'b0, 32'h0);

      // Aligned taken branch.
      do_reset();
      idle_cycle();
      fetch(32'h0000_0063);
      retire_cycle(1'b1, 32'h0000_0100);
      idle_cycle();
      check("branch_req", 32'(s_req), 32'd1);
      check("branch_addr", s_addr, 32'h0000_0100);

      // Misaligned taken branch faults, pc held, further acks ignored.
      do_reset();
      idle_cycle();
      fetch(32'h0000_0063);
      retire_cycle(1'b1, 32'h0000_0102);
      fetch(32'h0000_0033);
      check("misalign_halted", 32'(s_halted), 32'd1);
      check("misalign_req", 32'(s_req), 32'd0);
      check("misalign_pc", s_pc, RESET_PC);
      retire_cycle(1'b0, 32'h0);

      // Illegal opcode.
      do_reset();
      idle_cycle();
      fetch(32'h0000_007F);
      cnt_valid = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 32'h0000_0033, 1'b1, 1'b0, 32'h0);
         if (s_valid) cnt_valid++;
      end
      check("illegal_valid_count", 32'(cnt_valid), 32'd0);
      check("illegal_halted", 32'(s_halted), 32'd1);

      // pc wraps from the top of the address space.
      do_reset();
      idle_cycle();
      fetch(32'h0000_0063);
      retire_cycle(1'b1, 32'hFFFF_FFFC);
      fetch(32'h0000_0013);
      retire_cycle(1'b0, 32'h0);
      idle_cycle();
      check("wrap_addr", s_addr, 32'h0000_0000);

      // Reset in the middle of a pending request at a non-reset pc.
      do_reset();
      idle_cycle();
      fetch(32'h0000_0013);
      retire_cycle(1'b0, 32'h0);
      idle_cycle();
      check("midreq_pc_before", s_pc, 32'h4);
      cycle(1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
      check("midreq_req_in_rst", 32'(s_req), 32'd0);
      idle_cycle();
      check("midreq_idle_req", 32'(s_req), 32'd0);
      check("midreq_pc", s_pc, RESET_PC);
      idle_cycle();
      check("midreq_resume_req", 32'(s_req), 32'd1);

      // Randomized traffic: variable ack latency, stray acks, random
      // retire/branch behaviour, occasional faults and resets.
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 3) == 0);
         w   = $urandom();
         if ($urandom_range(0, 15) == 0) begin
            rnd = $urandom();
            w[6:0] = rnd[6:0];
         end else begin
            w[6:0] = legal_ops[$urandom_range(0, 4)];
         end
         tgt = $urandom();
         if ($urandom_range(0, 15) != 0) tgt[1:0] = 2'b00;
         cycle(r, ($urandom_range(0, 2) != 0), w, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0, tgt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
